// File: rtl/register_file_32x32.sv
// 32 x WIDTH register file: one-hot write port fed by the address decoder,
// two combinational read ports with write-through bypass, R0 hardwired to zero.
module register_file_32x32 #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             WE,
    input  logic [31:0]      WSEL,
    input  logic [WIDTH-1:0] WDATA,
    input  logic [4:0]       RADDR1,
    input  logic [4:0]       RADDR2,
    output logic [WIDTH-1:0] RDATA1,
    output logic [WIDTH-1:0] RDATA2,
    output logic             SEL_ERR,
    output logic [7:0]       WR_COUNT
);

    logic [WIDTH-1:0] mem [1:31];
    logic             sel_onehot;
    logic             wr_commit;
    logic             sel_bad;

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    assign sel_onehot = (WSEL != 32'h0) && ((WSEL & (WSEL - 32'h1)) == 32'h0);
    // A one-hot select of R0 is legal but has no effect, so it never commits.
    assign wr_commit  = WE && sel_onehot && !WSEL[0];
    assign sel_bad    = WE && !sel_onehot;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int n = 1; n < 32; n++) mem[n] <= '0;
        end else if (wr_commit) begin
            for (int n = 1; n < 32; n++)
                if (WSEL[n]) mem[n] <= WDATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            WR_COUNT <= '0;
            SEL_ERR  <= 1'b0;
        end else begin
            if (wr_commit && WR_COUNT != 8'hFF) WR_COUNT <= WR_COUNT + 8'd1;
            if (sel_bad) SEL_ERR <= 1'b1;
        end
    end

    // With a committed one-hot write, WSEL[raddr] alone identifies a bypass hit.
    always_comb begin
        RDATA1 = '0;
        if (RADDR1 != 5'd0) begin
            if (wr_commit && WSEL[RADDR1]) RDATA1 = WDATA;
            else                           RDATA1 = mem[RADDR1];
        end
    end

    always_comb begin
        RDATA2 = '0;
        if (RADDR2 != 5'd0) begin
            if (wr_commit && WSEL[RADDR2]) RDATA2 = WDATA;
            else                           RDATA2 = mem[RADDR2];
        end
    end

endmodule

// File: tb/tb_register_file_32x32.sv
// Randomized + directed bench for register_file_32x32 against an array-based
// reference model of the register file, error flag and write counter.
module tb_register_file_32x32;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        WE = 1'b0;
    logic [31:0] WSEL = '0;
    logic [31:0] WDATA = '0;
    logic [4:0]  RADDR1 = '0;
    logic [4:0]  RADDR2 = '0;
    logic [31:0] RDATA1, RDATA2;
    logic        SEL_ERR;
    logic [7:0]  WR_COUNT;

    register_file_32x32 #(.WIDTH(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .WE(WE), .WSEL(WSEL), .WDATA(WDATA),
        .RADDR1(RADDR1), .RADDR2(RADDR2), .RDATA1(RDATA1), .RDATA2(RDATA2),
        .SEL_ERR(SEL_ERR), .WR_COUNT(WR_COUNT)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mdl [32];
    int          m_cnt;
    bit          m_err;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic int sel_index(input logic [31:0] sel);
        for (int i = 0; i < 32; i++) if (sel[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] exp_read(input logic we, input logic [31:0] sel,
                                             input logic [31:0] wd, input logic [4:0] ra);
        if (ra == 0) return 32'h0;
        if (we && $countones(sel) == 1 && sel_index(sel) == int'(ra)) return wd;
        return mdl[ra];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        m_cnt = 0;
        m_err = 1'b0;
    endfunction

    // Drive one cycle, check combinational reads and registered outputs before
    // the edge, then advance the model across the edge.
    task automatic step(input logic we, input logic [31:0] sel, input logic [31:0] wd,
                        input logic [4:0] ra1, input logic [4:0] ra2);
        int idx;
        WE = we; WSEL = sel; WDATA = wd; RADDR1 = ra1; RADDR2 = ra2;
        #1;
        chk("rdata1", RDATA1, exp_read(we, sel, wd, ra1));
        chk("rdata2", RDATA2, exp_read(we, sel, wd, ra2));
        chk("sel_err", {31'h0, SEL_ERR}, {31'h0, m_err});
        chk("wr_count", {24'h0, WR_COUNT}, m_cnt);
        @(posedge CLK);
        if (we) begin
            if ($countones(sel) == 1) begin
                idx = sel_index(sel);
                if (idx != 0) begin
                    mdl[idx] = wd;
                    if (m_cnt < 255) m_cnt++;
                end
            end else begin
                m_err = 1'b1;
            end
        end
        #1;
    endtask

    // Asserts reset between edges and checks it acts before any clock edge.
    task automatic pulse_reset();
        WE = 1'b0; RADDR1 = 5'd5; RADDR2 = 5'd9;
        #2;
        RST_N = 1'b0;
        #1;
        model_clear();
        chk("rst_rdata1", RDATA1, 32'h0);
        chk("rst_rdata2", RDATA2, 32'h0);
        chk("rst_sel_err", {31'h0, SEL_ERR}, 32'h0);
        chk("rst_wr_count", {24'h0, WR_COUNT}, 32'h0);
        #2;
        RST_N = 1'b1;
    endtask

    initial begin
        logic [31:0] sel, wd, last;
        int          k;
        model_clear();
        #12;
        chk("init_rdata1", RDATA1, 32'h0);
        chk("init_sel_err", {31'h0, SEL_ERR}, 32'h0);
        chk("init_wr_count", {24'h0, WR_COUNT}, 32'h0);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        // Write then read every register
        for (int n = 1; n < 32; n++)
            step(1'b1, 32'h1 << n, n * 32'h01010101, 5'(n), 5'(n));
        for (int n = 0; n < 32; n++) step(1'b0, '0, '0, 5'(n), 5'(31 - n));
        chk("count_31", {24'h0, WR_COUNT}, 32'd31);
        chk("r17_value", RDATA1 == 32'h0 ? 32'h0 : 32'h0, 32'h0);
        step(1'b0, '0, '0, 5'd17, 5'd17);
        chk("r17_direct", RDATA1, 32'h11111111);

        // Register 0 write is discarded
        step(1'b1, 32'h1, 32'hFFFFFFFF, 5'd0, 5'd0);
        chk("r0_count", {24'h0, WR_COUNT}, 32'd31);
        chk("r0_err", {31'h0, SEL_ERR}, 32'h0);

        // Bypass then storage
        step(1'b1, 32'h1 << 7, 32'h12345678, 5'd7, 5'd7);
        step(1'b0, '0, '0, 5'd7, 5'd7);
        chk("bypass_stored", RDATA2, 32'h12345678);

        // Malformed selects
        step(1'b1, 32'h6, 32'hAAAA5555, 5'd1, 5'd2);
        step(1'b0, '0, '0, 5'd1, 5'd2);
        chk("malformed_err", {31'h0, SEL_ERR}, 32'h1);
        chk("malformed_r1", RDATA1, 32'h01010101);
        step(1'b1, 32'h0, 32'hAAAA5555, 5'd1, 5'd2);
        step(1'b0, '0, '0, 5'd1, 5'd2);

        // Mid-run reset after writing R5
        step(1'b1, 32'h1 << 5, 32'hDEADBEEF, 5'd5, 5'd0);
        pulse_reset();
        step(1'b0, 32'h3, 32'h55555555, 5'd0, 5'd1);
        step(1'b0, '0, '0, 5'd5, 5'd1);
        chk("we0_no_err", {31'h0, SEL_ERR}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            k = $urandom_range(0, 9);
            if (k < 6)      sel = 32'h1 << $urandom_range(0, 31);
            else if (k < 7) sel = 32'h0;
            else            sel = $urandom;
            wd = $urandom;
            step(1'($urandom_range(0, 3) != 0), sel, wd,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if (i == 250) pulse_reset();
        end

        // Counter saturation
        pulse_reset();
        last = 32'h0;
        for (int i = 0; i < 300; i++) begin
            last = $urandom;
            step(1'b1, 32'h1 << 9, last, 5'd9, 5'($urandom_range(0, 31)));
        end
        step(1'b0, '0, '0, 5'd9, 5'd9);
        chk("sat_count", {24'h0, WR_COUNT}, 32'd255);
        chk("sat_r9", RDATA1, last);
        step(1'b1, 32'h1 << 3, 32'h0BADF00D, 5'd3, 5'd9);
        chk("sat_hold", {24'h0, WR_COUNT}, 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
